mult_result_display: RTL and testbench
======================================

MULT_RESULT_DISPLAY -- requirements
Module: mult_result_display

Interface
REQ-001 SHALL have parameter: REFRESH_DIV, 1024, clock cycles each digit stays selected (range 2..65535).
REQ-002 SHALL have port: clk  input  1  single system clock; all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: prod  input  8  unsigned multiplier product, 0..255.
REQ-005 SHALL have port: prod_valid  input  1  one-cycle strobe; prod is valid in the same cycle.
REQ-006 SHALL have port: busy  output  1  high while a conversion is in progress.
REQ-007 SHALL have port: done  output  1  one-cycle pulse when bcd_out updates.
REQ-008 SHALL have port: overrun  output  1  one-cycle pulse when a prod_valid is dropped.
REQ-009 SHALL have port: bcd_out  output  12  last completed result {hundreds, tens, units}, 4 bits each.
REQ-010 SHALL have port: seg  output  7  active-high segments {g,f,e,d,c,b,a}.
REQ-011 SHALL have port: digit_sel  output  3  one-hot active-high digit enable, bit0=units, bit1=tens, bit2=hundreds.

Function
REQ-012 SHALL implement FSM states IDLE, CONVERT and SHOW; busy=1 only in CONVERT.
REQ-013 SHALL, when prod_valid is sampled high in IDLE or SHOW on edge k, latch prod, clear the BCD scratch and iteration count, and enter CONVERT.
REQ-014 SHALL perform double-dabble, one iteration per edge on edges k+1..k+8: each scratch nibble >=5 gets +3, then the {scratch, binary} register shifts left by 1.
REQ-015 SHALL, on edge k+9, load bcd_out from the scratch, assert done for exactly that cycle, and enter SHOW.
REQ-016 SHALL ignore prod_valid while in CONVERT (no restart, no effect on the result) and assert overrun for one cycle per ignored strobe.
REQ-017 SHALL restart a new conversion when prod_valid arrives in SHOW in the same cycle that done is high; the old bcd_out stays until the new done.
REQ-018 SHALL hold bcd_out stable except on a done edge; the display always shows bcd_out, including during CONVERT.
REQ-019 SHALL run a refresh counter 0..REFRESH_DIV-1 continuously; on wrap it SHALL advance the digit index units->tens->hundreds->units.
REQ-020 SHALL drive seg from the selected digit using the standard 0-9 encoding (0=7'h3F, 1=7'h06, 2=7'h5B, 5=7'h6D); nibble values >9 SHALL give seg=0.
REQ-021 SHALL blank leading zeros (seg=0, digit_sel still cycles): hundreds blank if 0; tens blank if hundreds=0 and tens=0; units never blank.
REQ-022 SHALL register seg and digit_sel so both change on the same edge, with no combinational path from prod to any output.

Reset
REQ-023 SHALL, while rst_n=0 (asynchronous), force: state=IDLE, busy=0, done=0, overrun=0, bcd_out=0, refresh counter=0, digit index=units, digit_sel=3'b001, seg=7'h3F.
REQ-024 SHALL abandon a conversion interrupted by reset with no done pulse, leaving bcd_out=0.

Structure
REQ-025 SHALL define in a shared package: the FSM state enum, the digit-index type, and the 7-segment pattern constants for digits 0-9 and blank.
REQ-026 SHALL contain one sub-module, bcd_seg7_decoder (combinational nibble+blank -> 7-bit pattern); the converter and the scan logic stay in the top.

Verification
REQ-027 SHALL cover: prod=8'hFF strobe -> busy for 9 cycles, done at k+9, bcd_out=12'h255, scan shows 2,5,5.
REQ-028 SHALL cover: prod=8'h0A -> bcd_out=12'h010; hundreds blank (seg=0), tens=7'h06, units=7'h3F.
REQ-029 SHALL cover: prod=8'h00 -> bcd_out=12'h000; only units lit with 7'h3F; prod=8'h64 -> 12'h100 with no blanking.
REQ-030 SHALL cover: prod_valid=8'h0C then prod_valid=8'h22 at k+3 -> overrun pulse at k+3, result 12'h012 only.
REQ-031 SHALL cover: rst_n low at k+4 during conversion of 8'h99 -> immediate reset values, no done; after release, display shows units '0'.
REQ-032 SHALL cover: REFRESH_DIV=4 -> digit_sel sequence 001,010,100,001 changing every 4 cycles.

Source files
------------

// File: rtl/mult_result_display_pkg.sv
// ============================================================================
//  mult_result_display_pkg : shared types and 7-segment patterns
//  Revision: 1.0
// ============================================================================
`default_nettype none

package mult_result_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_SHOW    = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        DIG_UNITS    = 2'd0,
        DIG_TENS     = 2'd1,
        DIG_HUNDREDS = 2'd2
    } digit_idx_e;

    // Segment order {g,f,e,d,c,b,a}, active high
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] DD_LAST_ITER = 4'd8;

    // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift
    function automatic logic [11:0] dd_adjust(input logic [11:0] s);
        logic [11:0] r;
        r = s;
        for (int n = 0; n < 3; n++) begin
            if (s[n*4 +: 4] >= 4'd5) begin
                r[n*4 +: 4] = s[n*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_seg7_decoder.sv
// ============================================================================
//  bcd_seg7_decoder : BCD nibble plus blank request to 7-segment pattern
//  Revision: 1.0
// ============================================================================
`default_nettype none

module bcd_seg7_decoder (
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);
    import mult_result_display_pkg::*;

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (nibble_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/mult_result_display.sv
// ============================================================================
//  mult_result_display : 8-bit product to BCD (double-dabble) with a
//  multiplexed, leading-zero-blanked 3-digit 7-segment display scan.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module mult_result_display #(
    parameter int unsigned REFRESH_DIV = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  prod,
    input  logic        prod_valid,
    output logic        busy,
    output logic        done,
    output logic        overrun,
    output logic [11:0] bcd_out,
    output logic [6:0]  seg,
    output logic [2:0]  digit_sel
);
    import mult_result_display_pkg::*;

    localparam int unsigned      CNT_W       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] REFRESH_MAX = CNT_W'(REFRESH_DIV - 1);

    state_e           state_q,     state_d;
    logic [7:0]       bin_q,       bin_d;
    logic [11:0]      scratch_q,   scratch_d;
    logic [3:0]       iter_q,      iter_d;
    logic [11:0]      bcd_out_q,   bcd_out_d;
    logic             done_q,      done_d;
    logic             overrun_q,   overrun_d;
    logic [CNT_W-1:0] refresh_q,   refresh_d;
    digit_idx_e       idx_q,       idx_d;
    logic [6:0]       seg_q,       seg_d;
    logic [2:0]       digit_sel_q, digit_sel_d;

    logic [3:0]       digit_nib;
    logic             digit_blank;

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        scratch_d = scratch_q;
        iter_d    = iter_q;
        bcd_out_d = bcd_out_q;
        done_d    = 1'b0;
        overrun_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_SHOW: begin
                if (prod_valid) begin
                    bin_d     = prod;
                    scratch_d = '0;
                    iter_d    = '0;
                    state_d   = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                overrun_d = prod_valid;
                if (iter_q == DD_LAST_ITER) begin
                    bcd_out_d = scratch_q;
                    done_d    = 1'b1;
                    state_d   = ST_SHOW;
                end else begin
                    {scratch_d, bin_d} = {dd_adjust(scratch_q), bin_q} << 1;
                    iter_d             = iter_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Free-running scan; digit index advances on each counter wrap
    always_comb begin
        refresh_d = refresh_q + 1'b1;
        idx_d     = idx_q;
        if (refresh_q == REFRESH_MAX) begin
            refresh_d = '0;
            case (idx_q)
                DIG_UNITS: idx_d = DIG_TENS;
                DIG_TENS:  idx_d = DIG_HUNDREDS;
                default:   idx_d = DIG_UNITS;
            endcase
        end
    end

    // Decode from next-state values so seg/digit_sel track idx and bcd_out exactly
    always_comb begin
        digit_nib   = bcd_out_d[3:0];
        digit_blank = 1'b0;
        digit_sel_d = 3'b001;
        case (idx_d)
            DIG_TENS: begin
                digit_nib   = bcd_out_d[7:4];
                digit_blank = (bcd_out_d[11:4] == 8'h00);
                digit_sel_d = 3'b010;
            end
            DIG_HUNDREDS: begin
                digit_nib   = bcd_out_d[11:8];
                digit_blank = (bcd_out_d[11:8] == 4'h0);
                digit_sel_d = 3'b100;
            end
            default: ;
        endcase
    end

    bcd_seg7_decoder u_decoder (
        .nibble_i (digit_nib),
        .blank_i  (digit_blank),
        .seg_o    (seg_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bin_q       <= '0;
            scratch_q   <= '0;
            iter_q      <= '0;
            bcd_out_q   <= '0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
            refresh_q   <= '0;
            idx_q       <= DIG_UNITS;
            seg_q       <= SEG_0;
            digit_sel_q <= 3'b001;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            scratch_q   <= scratch_d;
            iter_q      <= iter_d;
            bcd_out_q   <= bcd_out_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
            refresh_q   <= refresh_d;
            idx_q       <= idx_d;
            seg_q       <= seg_d;
            digit_sel_q <= digit_sel_d;
        end
    end

    assign busy      = (state_q == ST_CONVERT);
    assign done      = done_q;
    assign overrun   = overrun_q;
    assign bcd_out   = bcd_out_q;
    assign seg       = seg_q;
    assign digit_sel = digit_sel_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_result_display.sv
// ============================================================================
//  tb_mult_result_display : randomized self-checking bench for the BCD display
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mult_result_display;

    localparam int DIV = 4;

    logic        clk;
    logic        rst_n;
    logic [7:0]  prod;
    logic        prod_valid;
    logic        busy;
    logic        done;
    logic        overrun;
    logic [11:0] bcd_out;
    logic [6:0]  seg;
    logic [2:0]  digit_sel;

    int checks = 0;
    int errors = 0;

    logic [11:0] exp_bcd = 12'h000;
    int          m_cycles = 0;
    logic [6:0]  seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    mult_result_display #(.REFRESH_DIV(DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .prod       (prod),
        .prod_valid (prod_valid),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun),
        .bcd_out    (bcd_out),
        .seg        (seg),
        .digit_sel  (digit_sel)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference scan position: clock edges elapsed since reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_cycles <= 0;
        else        m_cycles <= m_cycles + 1;
    end

    function automatic logic [11:0] bcd_of(input int p);
        return {4'(p / 100), 4'((p / 10) % 10), 4'(p % 10)};
    endfunction

    function automatic int exp_idx();
        return (m_cycles / DIV) % 3;
    endfunction

    function automatic logic [2:0] exp_sel();
        return 3'(1 << exp_idx());
    endfunction

    function automatic logic [6:0] exp_seg();
        int h, t, u;
        h = int'(exp_bcd[11:8]);
        t = int'(exp_bcd[7:4]);
        u = int'(exp_bcd[3:0]);
        case (exp_idx())
            0:       return seg_tab[u];
            1:       return (h == 0 && t == 0) ? 7'h00 : seg_tab[t];
            default: return (h == 0) ? 7'h00 : seg_tab[h];
        endcase
    endfunction

    task automatic test_reset();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || overrun !== 1'b0 || bcd_out !== 12'h000) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b done=%b overrun=%b bcd_out=%03h, expected 0 0 0 000",
                     busy, done, overrun, bcd_out);
        end
        checks++;
        if (digit_sel !== 3'b001 || seg !== 7'h3F) begin
            errors++;
            $display("FAIL reset_display: digit_sel=%b seg=%02h, expected 001 3f", digit_sel, seg);
        end
    endtask

    // Starts at a negedge; returns at the negedge where done is expected high
    task automatic run_conversion(input logic [7:0] p);
        logic [11:0] old_bcd;
        old_bcd    = exp_bcd;
        prod       = p;
        prod_valid = 1'b1;
        @(negedge clk);
        prod_valid = 1'b0;
        prod       = 8'($urandom);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || overrun !== 1'b0 || bcd_out !== old_bcd) begin
                errors++;
                $display("FAIL convert_busy p=%02h cyc=%0d: busy=%b done=%b overrun=%b bcd_out=%03h, expected 1 0 0 %03h",
                         p, i, busy, done, overrun, bcd_out, old_bcd);
            end
            checks++;
            if (seg !== exp_seg() || digit_sel !== exp_sel()) begin
                errors++;
                $display("FAIL convert_display p=%02h cyc=%0d: seg=%02h sel=%b, expected %02h %b",
                         p, i, seg, digit_sel, exp_seg(), exp_sel());
            end
            @(negedge clk);
        end
        exp_bcd = bcd_of(int'(p));
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || bcd_out !== exp_bcd) begin
            errors++;
            $display("FAIL convert_done p=%02h: done=%b busy=%b bcd_out=%03h, expected 1 0 %03h",
                     p, done, busy, bcd_out, exp_bcd);
        end
        checks++;
        if (seg !== exp_seg() || digit_sel !== exp_sel()) begin
            errors++;
            $display("FAIL done_display p=%02h: seg=%02h sel=%b, expected %02h %b",
                     p, seg, digit_sel, exp_seg(), exp_sel());
        end
    endtask

    task automatic watch_display(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || overrun !== 1'b0 || bcd_out !== exp_bcd) begin
                errors++;
                $display("FAIL idle_ctrl cyc=%0d: busy=%b done=%b overrun=%b bcd_out=%03h, expected 0 0 0 %03h",
                         i, busy, done, overrun, bcd_out, exp_bcd);
            end
            checks++;
            if (seg !== exp_seg() || digit_sel !== exp_sel()) begin
                errors++;
                $display("FAIL scan bcd=%03h cyc=%0d: seg=%02h sel=%b, expected %02h %b",
                         exp_bcd, i, seg, digit_sel, exp_seg(), exp_sel());
            end
        end
    endtask

    task automatic test_vectors();
        logic [7:0] vec [4] = '{8'hFF, 8'h0A, 8'h00, 8'h64};
        for (int v = 0; v < 4; v++) begin
            run_conversion(vec[v]);
            watch_display(3 * DIV + 2);
        end
    endtask

    task automatic test_scan();
        logic [2:0] first;
        int         changes;
        first   = digit_sel;
        changes = 0;
        for (int i = 0; i < DIV; i++) begin
            @(negedge clk);
            if (digit_sel !== first) changes++;
        end
        checks++;
        if (changes != 1) begin
            errors++;
            $display("FAIL scan_period: digit_sel changed on %0d of %0d cycles, expected exactly 1",
                     changes, DIV);
        end
        watch_display(3 * DIV);
    endtask

    task automatic test_overrun();
        prod       = 8'h0C;
        prod_valid = 1'b1;
        @(negedge clk);
        prod_valid = 1'b0;
        repeat (2) @(negedge clk);
        prod       = 8'h22;
        prod_valid = 1'b1;
        @(negedge clk);
        prod_valid = 1'b0;
        checks++;
        if (overrun !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL overrun_pulse: overrun=%b busy=%b, expected 1 1", overrun, busy);
        end
        @(negedge clk);
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_width: overrun=%b, expected 0", overrun);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL overrun_busy: busy=%b done=%b, expected 1 0", busy, done);
        end
        @(negedge clk);
        exp_bcd = 12'h012;
        checks++;
        if (done !== 1'b1 || bcd_out !== exp_bcd) begin
            errors++;
            $display("FAIL overrun_result: done=%b bcd_out=%03h, expected 1 %03h", done, bcd_out, exp_bcd);
        end
        watch_display(3 * DIV);
    endtask

    task automatic test_back_to_back();
        run_conversion(8'hC8);
        run_conversion(8'h07);
        watch_display(3 * DIV);
    endtask

    task automatic test_reset_mid();
        prod       = 8'h99;
        prod_valid = 1'b1;
        @(negedge clk);
        prod_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_bcd = 12'h000;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || overrun !== 1'b0 || bcd_out !== 12'h000) begin
            errors++;
            $display("FAIL async_reset_ctrl: busy=%b done=%b overrun=%b bcd_out=%03h, expected 0 0 0 000",
                     busy, done, overrun, bcd_out);
        end
        checks++;
        if (digit_sel !== 3'b001 || seg !== 7'h3F) begin
            errors++;
            $display("FAIL async_reset_display: digit_sel=%b seg=%02h, expected 001 3f", digit_sel, seg);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        watch_display(3 * DIV + 4);
    endtask

    task automatic test_random();
        for (int r = 0; r < 16; r++) begin
            run_conversion(8'($urandom));
            watch_display(int'($urandom_range(1, 6)));
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        prod       = 8'h00;
        prod_valid = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_scan();
        test_vectors();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
